pillars_sweep_obstacle: RTL and testbench

PILLARS_SWEEP_OBSTACLE -- requirements
Module: pillars_sweep_obstacle

---
 rtl/pillars_sweep_obstacle.sv | 165 ++++++++++++++++
 tb/tb_pillars_sweep_obstacle.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pillars_sweep_obstacle.sv
// rtl/pillars_sweep_obstacle.sv - pillar that sweeps the arena perimeter and overlays onto the pixel stream
module pillars_sweep_obstacle #(
    parameter logic [3:0]  SELECT_CODE = 4'b0000,
    parameter int          ARENA_L     = 352,
    parameter int          ARENA_R     = 672,
    parameter int          ARENA_T     = 308,
    parameter int          ARENA_B     = 628,
    parameter int          PILLAR_W    = 20,
    parameter int          PILLAR_LEN  = 200,
    parameter int          STEP        = 1,
    parameter int          SPEEDUP     = 1,
    parameter int          STEP_MAX    = 4,
    parameter int          SWEEPS      = 3,
    parameter logic [11:0] COLOR       = 12'hfff
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] hcount_in,
    input  logic [11:0] vcount_in,
    input  logic [11:0] rgb_in,
    input  logic        menu_on,
    input  logic        play_selected,
    input  logic [3:0]  selected,
    input  logic        done_in,
    output logic [11:0] rgb_out,
    output logic [11:0] obstacle_x,
    output logic [11:0] obstacle_y,
    output logic        done
);

    localparam logic [11:0] A_L   = 12'(ARENA_L);
    localparam logic [11:0] A_R   = 12'(ARENA_R);
    localparam logic [11:0] A_T   = 12'(ARENA_T);
    localparam logic [11:0] A_B   = 12'(ARENA_B);
    localparam logic [11:0] P_W   = 12'(PILLAR_W);
    localparam logic [11:0] P_LEN = 12'(PILLAR_LEN);
    localparam logic [11:0] S_INI = 12'(STEP);
    localparam logic [11:0] S_INC = 12'(SPEEDUP);
    localparam logic [11:0] S_MAX = 12'(STEP_MAX);
    localparam logic [3:0]  N_RND = 4'(SWEEPS);

    typedef enum logic [2:0] {IDLE, SWEEP_L, SWEEP_D, SWEEP_R, SWEEP_U, FINISH} state_t;

    state_t      state, state_n;
    logic [11:0] pos, pos_n;
    logic [11:0] step, step_n;
    logic [3:0]  round, round_n;
    logic [11:0] step_inc;
    logic        tick, abort, start, in_sweep, hit;
    logic [11:0] x_lo, x_hi, y_lo, y_hi;

    assign tick     = (hcount_in == 12'd0) && (vcount_in == 12'd0);
    assign abort    = menu_on || !play_selected;
    assign start    = done_in && play_selected && (selected == SELECT_CODE);
    assign in_sweep = (state == SWEEP_L) || (state == SWEEP_D) ||
                      (state == SWEEP_R) || (state == SWEEP_U);
    assign step_inc = step + S_INC;

    always_comb begin
        state_n = state;
        pos_n   = pos;
        step_n  = step;
        round_n = round;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = SWEEP_L;
                    pos_n   = A_R - P_W;
                    round_n = 4'd0;
                    step_n  = S_INI;
                end
            end
            SWEEP_L, SWEEP_D, SWEEP_R, SWEEP_U: begin
                // Abort wins over a coincident tick, so pos stays frozen.
                if (abort) begin
                    state_n = IDLE;
                end else if (tick) begin
                    unique case (state)
                        SWEEP_L: begin
                            if (pos - A_L <= step) begin
                                state_n = SWEEP_D;
                                pos_n   = A_T;
                            end else begin
                                pos_n = pos - step;
                            end
                        end
                        SWEEP_D: begin
                            if ((A_B - P_W) - pos <= step) begin
                                state_n = SWEEP_R;
                                pos_n   = A_L;
                            end else begin
                                pos_n = pos + step;
                            end
                        end
                        SWEEP_R: begin
                            if ((A_R - P_W) - pos <= step) begin
                                state_n = SWEEP_U;
                                pos_n   = A_B - P_W;
                            end else begin
                                pos_n = pos + step;
                            end
                        end
                        default: begin
                            if (pos - A_T <= step) begin
                                if (round + 4'd1 == N_RND) begin
                                    state_n = FINISH;
                                end else begin
                                    state_n = SWEEP_L;
                                    round_n = round + 4'd1;
                                    step_n  = (step_inc > S_MAX) ? S_MAX : step_inc;
                                    pos_n   = A_R - P_W;
                                end
                            end else begin
                                pos_n = pos - step;
                            end
                        end
                    endcase
                end
            end
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Vertical legs move x; horizontal legs move y.
    always_comb begin
        x_lo = 12'd0;
        x_hi = 12'd0;
        y_lo = 12'd0;
        y_hi = 12'd0;
        unique case (state)
            SWEEP_L: begin x_lo = pos;           x_hi = pos + P_W; y_lo = A_T;         y_hi = A_T + P_LEN; end
            SWEEP_D: begin x_lo = A_R - P_LEN;   x_hi = A_R;       y_lo = pos;         y_hi = pos + P_W;   end
            SWEEP_R: begin x_lo = pos;           x_hi = pos + P_W; y_lo = A_B - P_LEN; y_hi = A_B;         end
            SWEEP_U: begin x_lo = A_L;           x_hi = A_L + P_LEN; y_lo = pos;       y_hi = pos + P_W;   end
            default: ;
        endcase
    end

    assign hit = in_sweep && (hcount_in >= x_lo) && (hcount_in < x_hi) &&
                 (vcount_in >= y_lo) && (vcount_in < y_hi);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pos        <= 12'd0;
            step       <= S_INI;
            round      <= 4'd0;
            rgb_out    <= 12'd0;
            obstacle_x <= 12'd0;
            obstacle_y <= 12'd0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            pos        <= pos_n;
            step       <= step_n;
            round      <= round_n;
            rgb_out    <= hit ? COLOR : rgb_in;
            obstacle_x <= hit ? hcount_in : 12'd0;
            obstacle_y <= hit ? vcount_in : 12'd0;
            done       <= (state == FINISH);
        end
    end

endmodule

// File: tb/tb_pillars_sweep_obstacle.sv
// tb/tb_pillars_sweep_obstacle.sv - scoreboard bench with a perimeter-walk reference model
module tb_pillars_sweep_obstacle;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] hcount_in, vcount_in, rgb_in;
    logic        menu_on, play_selected, done_in;
    logic [3:0]  selected;
    logic [11:0] rgb_out, obstacle_x, obstacle_y;
    logic        done;

    always #5 clk = ~clk;

    pillars_sweep_obstacle dut (
        .clk(clk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .rgb_in(rgb_in),
        .menu_on(menu_on), .play_selected(play_selected),
        .selected(selected), .done_in(done_in),
        .rgb_out(rgb_out), .obstacle_x(obstacle_x), .obstacle_y(obstacle_y),
        .done(done)
    );

    typedef struct {
        logic [11:0] rgb;
        logic [11:0] x;
        logic [11:0] y;
        logic        dn;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;
    int runs_done = 0;
    int dones_seen = 0;
    bit stim_over = 0;

    // Model: leg 0 idle, 1..4 = left, down, right, up walk, 5 = finish.
    int m_leg, m_pos, m_round, m_step;

    function automatic bit model_hit(int h, int v);
        int xl, xh, yl, yh;
        case (m_leg)
            1: begin xl = m_pos; xh = m_pos + 20; yl = 308; yh = 508; end
            2: begin xl = 472;   xh = 672;        yl = m_pos; yh = m_pos + 20; end
            3: begin xl = m_pos; xh = m_pos + 20; yl = 428; yh = 628; end
            4: begin xl = 352;   xh = 552;        yl = m_pos; yh = m_pos + 20; end
            default: return 1'b0;
        endcase
        return (h >= xl) && (h < xh) && (v >= yl) && (v < yh);
    endfunction

    task automatic model_advance(bit r, int h, int v, bit menu, bit play, int sel, bit din);
        bit tk = (h == 0) && (v == 0);
        if (r) begin
            m_leg = 0; m_pos = 0; m_round = 0; m_step = 1;
        end else if (m_leg == 0) begin
            if (din && play && sel == 0) begin
                m_leg = 1; m_pos = 652; m_round = 0; m_step = 1;
            end
        end else if (m_leg == 5) begin
            m_leg = 0;
        end else if (menu || !play) begin
            m_leg = 0;
        end else if (tk) begin
            case (m_leg)
                1: if (m_pos - 352 <= m_step) begin m_leg = 2; m_pos = 308; end else m_pos -= m_step;
                2: if (608 - m_pos <= m_step) begin m_leg = 3; m_pos = 352; end else m_pos += m_step;
                3: if (652 - m_pos <= m_step) begin m_leg = 4; m_pos = 608; end else m_pos += m_step;
                default:
                    if (m_pos - 308 <= m_step) begin
                        if (m_round + 1 == 3) begin
                            m_leg = 5;
                            runs_done++;
                        end else begin
                            m_round++;
                            m_step = (m_step + 1 > 4) ? 4 : m_step + 1;
                            m_leg = 1;
                            m_pos = 652;
                        end
                    end else m_pos -= m_step;
            endcase
        end
    endtask

    task automatic cyc(bit r, int h, int v, int rgb, bit menu, bit play, int sel, bit din);
        exp_t e;
        @(negedge clk);
        rst = r; hcount_in = 12'(h); vcount_in = 12'(v); rgb_in = 12'(rgb);
        menu_on = menu; play_selected = play; selected = 4'(sel); done_in = din;
        if (r) begin
            e.rgb = 12'd0; e.x = 12'd0; e.y = 12'd0; e.dn = 1'b0;
        end else begin
            e.dn = (m_leg == 5);
            if (model_hit(h, v)) begin
                e.rgb = 12'hfff; e.x = 12'(h); e.y = 12'(v);
            end else begin
                e.rgb = 12'(rgb); e.x = 12'd0; e.y = 12'd0;
            end
        end
        q.push_back(e);
        model_advance(r, h, v, menu, play, sel, din);
    endtask

    task automatic rand_cyc(bit menu);
        bit tk = ($urandom_range(0, 1) == 1);
        int h = tk ? 0 : $urandom_range(340, 690);
        int v = tk ? 0 : $urandom_range(296, 640);
        cyc(1'b0, h, v, $urandom_range(0, 4095), menu, 1'b1, $urandom_range(0, 1), $urandom_range(0, 1));
    endtask

    task automatic start_run();
        cyc(1'b0, 5, 5, 12'h0aa, 1'b0, 1'b1, 0, 1'b1);
    endtask

    // Monitor: one expected entry per clock, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done) dones_seen++;
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                if (rgb_out !== e.rgb || obstacle_x !== e.x || obstacle_y !== e.y || done !== e.dn) begin
                    miscompares++;
                    if (miscompares < 20)
                        $display("FAIL pixel t=%0t got rgb=%h x=%0d y=%0d done=%b want rgb=%h x=%0d y=%0d done=%b",
                                 $time, rgb_out, obstacle_x, obstacle_y, done, e.rgb, e.x, e.y, e.dn);
                end
            end
        end
    end

    initial begin
        int budget;
        m_leg = 0; m_pos = 0; m_round = 0; m_step = 1;
        rst = 1'b1; hcount_in = 0; vcount_in = 0; rgb_in = 0;
        menu_on = 0; play_selected = 0; selected = 0; done_in = 0;

        cyc(1'b1, 0, 0, 12'h555, 1'b0, 1'b1, 0, 1'b1);
        cyc(1'b1, 0, 0, 12'h555, 1'b0, 1'b1, 0, 1'b1);

        // No start: wrong code, done_in low, play not selected.
        cyc(1'b0, 660, 310, 12'h321, 1'b0, 1'b1, 3, 1'b1);
        cyc(1'b0, 660, 310, 12'h321, 1'b0, 1'b1, 0, 1'b0);
        cyc(1'b0, 660, 310, 12'h321, 1'b0, 1'b0, 0, 1'b1);
        cyc(1'b0, 660, 310, 12'h321, 1'b0, 1'b1, 0, 1'b0);

        start_run();
        cyc(1'b0, 660, 310, 12'h123, 1'b0, 1'b1, 0, 1'b0);
        cyc(1'b0, 660, 600, 12'h123, 1'b0, 1'b1, 0, 1'b0);
        cyc(1'b0, 652, 308, 12'h123, 1'b0, 1'b1, 0, 1'b0);
        cyc(1'b0, 651, 507, 12'h123, 1'b0, 1'b1, 0, 1'b0);
        cyc(1'b0, 0, 0, 12'h123, 1'b0, 1'b1, 0, 1'b0);
        cyc(1'b0, 651, 320, 12'h123, 1'b0, 1'b1, 0, 1'b0);
        cyc(1'b0, 671, 320, 12'h123, 1'b0, 1'b1, 0, 1'b0);

        // Walk into the down leg, then reset mid-run for two cycles.
        budget = 0;
        while (m_leg != 2 && budget < 2000) begin rand_cyc(1'b0); budget++; end
        repeat (10) rand_cyc(1'b0);
        cyc(1'b1, 600, 400, 12'h777, 1'b0, 1'b1, 0, 1'b1);
        cyc(1'b1, 0, 0, 12'h777, 1'b0, 1'b1, 0, 1'b1);
        repeat (5) cyc(1'b0, 600, 400, 12'h777, 1'b0, 1'b1, 1, 1'b0);

        // Abort on a tick during the right leg.
        start_run();
        budget = 0;
        while (m_leg != 3 && budget < 3000) begin rand_cyc(1'b0); budget++; end
        cyc(1'b0, 0, 0, 12'h111, 1'b1, 1'b1, 0, 1'b0);
        repeat (5) rand_cyc(1'b0);

        // Complete runs with occasional random aborts.
        for (int r = 0; r < 3; r++) begin
            start_run();
            budget = 0;
            while (m_leg != 0 && budget < 9000) begin
                rand_cyc(r == 2 && $urandom_range(0, 2999) == 0);
                budget++;
            end
            if (m_leg != 0) begin
                miscompares++;
                $display("FAIL run_budget run=%0d got leg=%0d want leg=0", r, m_leg);
            end
            repeat (4) rand_cyc(1'b0);
        end

        stim_over = 1;
        budget = 0;
        while (q.size() > 0 && budget < 10) begin @(posedge clk); budget++; end
        @(posedge clk); #2;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        vectors++;
        if (dones_seen != runs_done || runs_done < 2) begin
            miscompares++;
            $display("FAIL done_count got %0d pulses want %0d (runs>=2)", dones_seen, runs_done);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
